// File: rtl/switch_box_config_loader.sv
// rtl/switch_box_config_loader.sv - word-to-serial loader for the switch-box configuration chain
// Shifts words LSB-first into the chain and strobes the latch once CHAIN_LEN bits have gone out.
module switch_box_config_loader #(
  parameter int CHAIN_LEN = 96,
  parameter int WORD_W    = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [WORD_W-1:0]              in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           cfg_out,
  output logic                           cfg_shift,
  output logic                           cfg_latch,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int RW = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_WORD,
    S_SHIFT,
    S_LATCH,
    S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [WORD_W-1:0] shreg;
  logic [RW-1:0]     remaining;
  logic [31:0]       bits_left;
  logic [RW-1:0]     rem_load;
  logic              last_bit;

  // A short final word only contributes the bits the chain still needs.
  assign bits_left = 32'(CHAIN_LEN) - 32'(bit_count);
  assign rem_load  = (bits_left < 32'(WORD_W)) ? RW'(bits_left) : RW'(WORD_W);
  assign last_bit  = ((32'(bit_count) + 32'd1) == 32'(CHAIN_LEN));

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    cfg_out   = 1'b0;
    cfg_shift = 1'b0;
    cfg_latch = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_WAIT_WORD;
      end
      S_WAIT_WORD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        cfg_shift = 1'b1;
        cfg_out   = shreg[0];
        busy      = 1'b1;
        if (remaining == RW'(1)) state_nx = last_bit ? S_LATCH : S_WAIT_WORD;
      end
      S_LATCH: begin
        cfg_latch = 1'b1;
        busy      = 1'b1;
        state_nx  = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nx = S_WAIT_WORD;
      end
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      remaining <= '0;
      bit_count <= '0;
    end else begin
      state <= state_nx;
      if (abort) begin
        shreg     <= '0;
        remaining <= '0;
        bit_count <= '0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) bit_count <= '0;
          end
          S_WAIT_WORD: begin
            if (in_valid) begin
              shreg     <= in_data;
              remaining <= rem_load;
            end
          end
          S_SHIFT: begin
            shreg     <= shreg >> 1;
            bit_count <= bit_count + CW'(1);
            remaining <= remaining - RW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_switch_box_config_loader.sv
// tb/tb_switch_box_config_loader.sv - directed bench for switch_box_config_loader
module tb_switch_box_config_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, in_valid;
  logic [31:0] in_data;

  logic r1, o1, s1, l1, b1, d1;
  logic [6:0] bc1;
  logic r2, o2, s2, l2, b2, d2;
  logic [5:0] bc2;

  logic sel;
  logic o_ready, o_out, o_shift, o_latch, o_busy, o_done;
  logic [6:0] o_bc;

  int n_cmp = 0;
  int n_bad = 0;

  int n_shift, n_latch, latch_cyc, done_cyc, done_bc, gap_rdy, ab_bc;
  logic [127:0] stream;
  logic [255:0] ready_v;
  logic ab_busy, ab_ready, ab_shift, rs_done, rs_ready;

  always #5 clk = ~clk;

  switch_box_config_loader #(.CHAIN_LEN(96), .WORD_W(32)) dut_full (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(r1),
    .cfg_out(o1), .cfg_shift(s1), .cfg_latch(l1),
    .busy(b1), .done(d1), .bit_count(bc1)
  );

  switch_box_config_loader #(.CHAIN_LEN(40), .WORD_W(32)) dut_part (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(r2),
    .cfg_out(o2), .cfg_shift(s2), .cfg_latch(l2),
    .busy(b2), .done(d2), .bit_count(bc2)
  );

  always_comb begin
    o_ready = sel ? r2 : r1;
    o_out   = sel ? o2 : o1;
    o_shift = sel ? s2 : s1;
    o_latch = sel ? l2 : l1;
    o_busy  = sel ? b2 : b1;
    o_done  = sel ? d2 : d1;
    o_bc    = sel ? {1'b0, bc2} : bc1;
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Pulses start, then records outputs per cycle while feeding words as in_ready allows.
  task automatic run_load(input int nw, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input int gap_word, input int gap_len,
                          input int start_at, input int abort_at, input int max_cyc);
    logic [31:0] words [3];
    int wi, cyc, gap_cnt;
    words[0] = w0; words[1] = w1; words[2] = w2;
    n_shift = 0; n_latch = 0; latch_cyc = -1; done_cyc = -1; done_bc = -1;
    gap_rdy = 0; ab_bc = -1; stream = '0; ready_v = '0;
    ab_busy = 1'bx; ab_ready = 1'bx; ab_shift = 1'bx; rs_done = 1'bx; rs_ready = 1'bx;
    @(posedge clk);
    #1;
    start = 1'b1; abort = 1'b0; in_valid = (nw > 0); in_data = w0;
    cyc = 0; wi = 0; gap_cnt = 0;
    while (cyc < max_cyc) begin
      @(posedge clk);
      cyc++;
      #1;
      ready_v[cyc] = o_ready;
      if (o_shift) begin
        if (n_shift < 128) stream[n_shift] = o_out;
        n_shift++;
      end
      if (o_latch) begin
        latch_cyc = cyc;
        n_latch++;
      end
      if (o_done && done_cyc < 0) begin
        done_cyc = cyc;
        done_bc  = int'(o_bc);
      end
      if (cyc == abort_at + 1) begin
        ab_busy = o_busy; ab_ready = o_ready; ab_shift = o_shift; ab_bc = int'(o_bc);
      end
      if (cyc == start_at + 1) begin
        rs_done = o_done; rs_ready = o_ready;
      end
      start = (cyc == start_at);
      abort = (cyc == abort_at);
      if (wi == gap_word && gap_cnt < gap_len && (gap_cnt > 0 || o_ready)) begin
        in_valid = 1'b0;
        gap_cnt++;
        if (o_ready) gap_rdy++;
      end else begin
        in_valid = (wi < nw);
        in_data  = (wi < nw) ? words[wi] : 32'h0;
        if (o_ready && in_valid) wi++;
      end
    end
    start = 1'b0; abort = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; sel = 1'b0;
    do_reset();
    n_cmp++;
    if ({r1, o1, s1, l1, b1, d1} !== 6'b0) begin
      n_bad++; $display("FAIL reset_outs_full: got %b want 000000", {r1, o1, s1, l1, b1, d1});
    end
    n_cmp++;
    if (bc1 !== 7'd0) begin n_bad++; $display("FAIL reset_bc_full: got %0d want 0", bc1); end
    n_cmp++;
    if ({r2, o2, s2, l2, b2, d2} !== 6'b0) begin
      n_bad++; $display("FAIL reset_outs_part: got %b want 000000", {r2, o2, s2, l2, b2, d2});
    end
    n_cmp++;
    if (bc2 !== 6'd0) begin n_bad++; $display("FAIL reset_bc_part: got %0d want 0", bc2); end
  endtask

  task automatic test_full_load();
    sel = 1'b0;
    do_reset();
    run_load(3, 32'hA5A5_0F0F, 32'h1234_5678, 32'hFFFF_0000, -1, 0, -1, -1, 104);
    n_cmp++;
    if (n_shift != 96) begin n_bad++; $display("FAIL full_shifts: got %0d want 96", n_shift); end
    n_cmp++;
    if (stream[95:0] !== 96'hFFFF0000_12345678_A5A50F0F) begin
      n_bad++; $display("FAIL full_stream: got %h want FFFF000012345678A5A50F0F", stream[95:0]);
    end
    n_cmp++;
    if (latch_cyc != 100 || n_latch != 1) begin
      n_bad++; $display("FAIL full_latch: got cycle %0d count %0d want cycle 100 count 1", latch_cyc, n_latch);
    end
    n_cmp++;
    if (done_cyc != 101 || done_bc != 96) begin
      n_bad++; $display("FAIL full_done: got cycle %0d bc %0d want cycle 101 bc 96", done_cyc, done_bc);
    end
    n_cmp++;
    if (!(ready_v[1] && ready_v[34] && ready_v[67]) || $countones(ready_v) != 3) begin
      n_bad++; $display("FAIL full_ready_cycles: got %0d ready cycles want 3 at 1,34,67", $countones(ready_v));
    end
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    do_reset();
    run_load(3, 32'hA5A5_0F0F, 32'h1234_5678, 32'hFFFF_0000, 1, 5, -1, -1, 110);
    n_cmp++;
    if (gap_rdy != 5) begin n_bad++; $display("FAIL bp_ready_gap: got %0d want 5", gap_rdy); end
    n_cmp++;
    if (n_shift != 96 || stream[95:0] !== 96'hFFFF0000_12345678_A5A50F0F) begin
      n_bad++; $display("FAIL bp_stream: got %0d bits %h want 96 bits FFFF000012345678A5A50F0F", n_shift, stream[95:0]);
    end
    n_cmp++;
    if (latch_cyc != 105 || n_latch != 1) begin
      n_bad++; $display("FAIL bp_latch: got cycle %0d count %0d want cycle 105 count 1", latch_cyc, n_latch);
    end
  endtask

  task automatic test_partial_word();
    sel = 1'b1;
    do_reset();
    run_load(2, 32'hFFFF_FFFF, 32'h0000_00AB, 32'h0, -1, 0, -1, -1, 50);
    n_cmp++;
    if (n_shift != 40) begin n_bad++; $display("FAIL part_shifts: got %0d want 40", n_shift); end
    n_cmp++;
    if (stream[39:0] !== 40'hAB_FFFFFFFF) begin
      n_bad++; $display("FAIL part_stream: got %h want ABFFFFFFFF", stream[39:0]);
    end
    n_cmp++;
    if (latch_cyc != 43 || n_latch != 1) begin
      n_bad++; $display("FAIL part_latch: got cycle %0d count %0d want cycle 43 count 1", latch_cyc, n_latch);
    end
    n_cmp++;
    if (done_bc != 40) begin n_bad++; $display("FAIL part_done_bc: got %0d want 40", done_bc); end
    sel = 1'b0;
  endtask

  task automatic test_abort();
    sel = 1'b0;
    do_reset();
    run_load(3, 32'hA5A5_0F0F, 32'h1234_5678, 32'hFFFF_0000, -1, 0, -1, 40, 120);
    n_cmp++;
    if (ab_busy !== 1'b0 || ab_ready !== 1'b0 || ab_shift !== 1'b0 || ab_bc != 0) begin
      n_bad++; $display("FAIL abort_state: got busy %b ready %b shift %b bc %0d want 0 0 0 0", ab_busy, ab_ready, ab_shift, ab_bc);
    end
    n_cmp++;
    if (n_latch != 0 || done_cyc != -1) begin
      n_bad++; $display("FAIL abort_no_latch: got latches %0d done cycle %0d want 0 and -1", n_latch, done_cyc);
    end
    run_load(3, 32'h0BAD_F00D, 32'hC0DE_1234, 32'h8000_0001, -1, 0, -1, -1, 104);
    n_cmp++;
    if (stream[95:0] !== 96'h80000001_C0DE1234_0BADF00D || latch_cyc != 100 || n_latch != 1) begin
      n_bad++; $display("FAIL abort_reload: got %h latch %0d want 80000001C0DE12340BADF00D latch 100", stream[95:0], latch_cyc);
    end
  endtask

  task automatic test_start_while_busy();
    sel = 1'b0;
    do_reset();
    run_load(3, 32'hA5A5_0F0F, 32'h1234_5678, 32'hFFFF_0000, -1, 0, 20, -1, 104);
    n_cmp++;
    if (latch_cyc != 100 || done_cyc != 101 || stream[95:0] !== 96'hFFFF0000_12345678_A5A50F0F) begin
      n_bad++; $display("FAIL busy_start: got latch %0d done %0d want latch 100 done 101", latch_cyc, done_cyc);
    end
    do_reset();
    run_load(3, 32'hA5A5_0F0F, 32'h1234_5678, 32'hFFFF_0000, -1, 0, 102, -1, 106);
    n_cmp++;
    if (done_cyc != 101) begin n_bad++; $display("FAIL restart_first_done: got %0d want 101", done_cyc); end
    n_cmp++;
    if (rs_done !== 1'b0 || rs_ready !== 1'b1) begin
      n_bad++; $display("FAIL restart_from_done: got done %b ready %b want 0 1", rs_done, rs_ready);
    end
  endtask

  task automatic test_reset_midload();
    int latches, busies;
    sel = 1'b0;
    do_reset();
    run_load(3, 32'hA5A5_0F0F, 32'h1234_5678, 32'hFFFF_0000, -1, 0, -1, -1, 10);
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (bc1 !== 7'd8 || b1 !== 1'b1 || s1 !== 1'b1) begin
      n_bad++; $display("FAIL reset_no_edge: got bc %0d busy %b shift %b want 8 1 1", bc1, b1, s1);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bc1 !== 7'd9) begin n_bad++; $display("FAIL reset_no_edge_continue: got %0d want 9", bc1); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_cmp++;
    if ({r1, o1, s1, l1, b1, d1} !== 6'b0 || bc1 !== 7'd0) begin
      n_bad++; $display("FAIL reset_midload: got outs %b bc %0d want 000000 0", {r1, o1, s1, l1, b1, d1}, bc1);
    end
    latches = 0; busies = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #1;
      if (l1) latches++;
      if (b1) busies++;
    end
    n_cmp++;
    if (latches != 0 || busies != 0) begin
      n_bad++; $display("FAIL reset_midload_quiet: got latches %0d busy cycles %0d want 0 0", latches, busies);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_backpressure();
    test_partial_word();
    test_abort();
    test_start_while_busy();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/switch_box_config_loader.md
# switch_box_config_loader

Serial configuration loader for the switch-box routing fabric. Accepts configuration words over a valid/ready handshake and shifts them LSB-first into the fabric's serial configuration chain. When exactly `CHAIN_LEN` bits have been shifted, it pulses a latch strobe so the shadow chain becomes the active connection pattern. It sits between the bitstream source (host interface or boot ROM reader) and the config chain threading all switch-box connectors.

## Interface

**Parameters**
- `CHAIN_LEN`, default 96: total configuration bits in the chain; must be ≥ 1.
- `WORD_W`, default 32: input word width; must be ≥ 1.

**Ports**
- Clocking and reset: one clock; reset is synchronous and active-low.
  - `clk`, input, 1: clock; all state updates on the rising edge.
  - `rst_n`, input, 1: synchronous, active-low reset.
- Control:
  - `start`, input, 1: begin a load; sampled only in IDLE or DONE.
  - `abort`, input, 1: cancel the load; return to IDLE, no latch.
- Word input:
  - `in_data`, input, `WORD_W`: configuration word; bit 0 is shifted first.
  - `in_valid`, input, 1: `in_data` valid.
  - `in_ready`, output, 1: loader accepts a word this cycle.
- Configuration chain:
  - `cfg_out`, output, 1: serial config bit.
  - `cfg_shift`, output, 1: chain shift enable; chain captures `cfg_out` when high.
  - `cfg_latch`, output, 1: one-cycle strobe; chain copies shadow bits to active.
- Status:
  - `busy`, output, 1: high in WAIT_WORD, SHIFT and LATCH.
  - `done`, output, 1: high in DONE.
  - `bit_count`, output, `$clog2(CHAIN_LEN+1)`: bits shifted in the current load.

## Operation

- **States:** IDLE, WAIT_WORD, SHIFT, LATCH, DONE.
- **IDLE:** all outputs low.
  - `start` → WAIT_WORD; clear `bit_count`.
- **WAIT_WORD:** `in_ready`=1.
  - On `in_valid && in_ready`: load the shift register with `in_data`.
  - Set the word-bits-remaining counter to min(`WORD_W`, `CHAIN_LEN` − `bit_count`).
  - → SHIFT.
- **SHIFT:** each cycle:
  - `cfg_shift`=1 and `cfg_out`=shreg[0].
  - Shift shreg right by 1; increment `bit_count`; decrement remaining.
  - On the cycle remaining reaches 1: → LATCH if `bit_count`+1 == `CHAIN_LEN`, else → WAIT_WORD.
- **LATCH:** `cfg_latch`=1 for exactly one cycle, with `cfg_shift`=0 → DONE.
- **DONE:** `done`=1, held.
  - `bit_count` holds `CHAIN_LEN`.
  - `start` → WAIT_WORD; `done` drops and `bit_count` clears.
- **Partial last word:** when `CHAIN_LEN` mod `WORD_W` ≠ 0, the unused upper bits of the last word are discarded and never shifted.
- **start in other states:** ignored in WAIT_WORD, SHIFT and LATCH.
- **abort:** in any state, takes priority over all other transitions.
  - Next state is IDLE; `bit_count` clears.
  - No `cfg_latch` is issued, so the active configuration is unchanged.
- **Words presented outside WAIT_WORD:** `in_ready`=0, so they are not consumed. Upstream must hold `in_valid`/`in_data` stable until accepted.
- **Output decode:** all outputs are decoded from registered state only; no combinational input-to-output paths.

## Timing

- **Reset:** with `rst_n`=0 at a rising edge, the next cycle has:
  - state IDLE;
  - `in_ready`, `cfg_out`, `cfg_shift`, `cfg_latch`, `busy`, `done` all 0;
  - `bit_count`=0;
  - shreg=0.
  - Reset mid-load behaves exactly like `abort`.
- **start:** `start` sampled at edge 0 gives `in_ready`=1 in cycle 1.
- **Word transfer:** occurs in the cycle where `in_valid` and `in_ready` are both high at the edge.
  - Its first bit appears on `cfg_out` with `cfg_shift`=1 in the following cycle.
- **Per-word cost:** 1 handshake cycle plus k shift cycles, where k is the number of bits taken from that word.
  - No overlap between handshake and shift.
- **Default parameters, `in_valid` continuously high:**
  - WAIT_WORD in cycles 1, 34, 67; SHIFT in 2–33, 35–66, 68–99.
  - `cfg_latch` in cycle 100; `done` from cycle 101.
- **Stalls:** each cycle `in_valid` is low in WAIT_WORD adds one cycle. Shifting never stalls once started.

## Test plan

- **Full load, default parameters:** `in_valid` held with words 0xA5A5_0F0F, 0x1234_5678, 0xFFFF_0000.
  - 96 `cfg_shift` pulses; `cfg_out` stream equals the words LSB-first in order.
  - `cfg_latch` exactly at cycle 100; `done`=1 and `bit_count`=96 from cycle 101.
- **Backpressure:** deassert `in_valid` for 5 cycles before word 2.
  - `in_ready` stays high throughout the gap; the stream is unchanged.
  - `cfg_latch` shifts to cycle 105.
- **Partial word:** `CHAIN_LEN`=40, `WORD_W`=32, words 0xFFFF_FFFF, 0x0000_00AB.
  - 40 shift pulses; last 8 bits are 1,1,0,1,0,1,0,1; upper 24 bits of word 2 are never shifted.
  - `cfg_latch` at cycle 1+33+9=43.
- **Abort:** assert `abort` during SHIFT of word 2.
  - Next cycle: IDLE, `busy`=0, `bit_count`=0; `cfg_latch` never asserts.
  - A subsequent `start` performs a clean full load.
- **Start while busy and restart from DONE:**
  - `start` pulsed during SHIFT has no effect on timing.
  - `start` in DONE drops `done` the next cycle and `in_ready`=1.
- **Synchronous reset mid-load:** `rst_n`=0 for one edge during SHIFT.
  - All outputs 0 the next cycle; no `cfg_latch`.
  - Asserting `rst_n`=0 with no clock edge changes nothing.
